// File: rtl/data_upsizer_if.sv
// Beat-in / word-out bus for the width up-converter.
// Slave modport is the converter; master is whoever drives beats and sinks words.
interface data_upsizer_if #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
);
  logic [DWIDTH-1:0]        i_data;
  logic                     i_valid;
  logic                     i_last;
  logic                     o_ready;
  logic [DWIDTH*RATIO-1:0]  o_data;
  logic [RATIO-1:0]         o_keep;
  logic                     o_last;
  logic                     o_valid;
  logic                     i_ready;

  modport slave (
    input  i_data, i_valid, i_last, i_ready,
    output o_ready, o_data, o_keep, o_last, o_valid
  );

  modport master (
    output i_data, i_valid, i_last, i_ready,
    input  o_ready, o_data, o_keep, o_last, o_valid
  );
endinterface

// File: rtl/data_upsizer.sv
// Packs RATIO beats into one word (i_last closes early); word valid 1 cycle after final beat.
// Backpressure: o_ready drops while a word is held and i_ready is low; releases combinationally.
module data_upsizer #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
) (
  input  logic           clk,
  input  logic           rstn,
  data_upsizer_if.slave  bus
);
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WW = DWIDTH * RATIO;

  logic              en_q, en_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     acc_q, acc_d, acc_m;
  logic [RATIO-1:0]  kacc_q, kacc_d, kacc_m;
  logic [WW-1:0]     o_data_q, o_data_d;
  logic [RATIO-1:0]  o_keep_q, o_keep_d;
  logic              o_last_q, o_last_d;
  logic              o_valid_q, o_valid_d;
  logic              rdy, accept, final_beat;

  always_comb begin
    en_d       = 1'b1;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    kacc_d     = kacc_q;
    o_data_d   = o_data_q;
    o_keep_d   = o_keep_q;
    o_last_d   = o_last_q;
    o_valid_d  = o_valid_q;

    rdy        = en_q && (!o_valid_q || bus.i_ready);
    accept     = bus.i_valid && rdy;
    final_beat = accept && ((cnt_q == CW'(RATIO - 1)) || bus.i_last);

    // Accumulator with the current beat merged into lane cnt_q.
    acc_m  = acc_q;
    kacc_m = kacc_q;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
        acc_m[k*DWIDTH +: DWIDTH] = bus.i_data;
        kacc_m[k]                 = 1'b1;
      end
    end

    if (o_valid_q && bus.i_ready) begin
      o_valid_d = 1'b0;
    end

    if (final_beat) begin
      o_data_d  = acc_m;
      o_keep_d  = kacc_m;
      o_last_d  = bus.i_last;
      o_valid_d = 1'b1;
      acc_d     = '0;
      kacc_d    = '0;
      cnt_d     = '0;
    end else if (accept) begin
      acc_d  = acc_m;
      kacc_d = kacc_m;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      en_q      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      kacc_q    <= '0;
      o_data_q  <= '0;
      o_keep_q  <= '0;
      o_last_q  <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      kacc_q    <= kacc_d;
      o_data_q  <= o_data_d;
      o_keep_q  <= o_keep_d;
      o_last_q  <= o_last_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign bus.o_ready = rdy;
  assign bus.o_data  = o_data_q;
  assign bus.o_keep  = o_keep_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_valid = o_valid_q;
endmodule

// File: doc/data_upsizer.md
# data_upsizer

Width up-converter that packs RATIO consecutive DWIDTH-bit beats into one DWIDTH*RATIO-bit word, with valid-ready handshaking on both sides. It sits directly downstream of the skid_buffer: it consumes that block's o_data/o_valid and drives its i_ready. An i_last input closes a word early. The resulting partial word is flagged with a lane-keep mask.

## Interface
- DWIDTH, 8, width of one input beat.
- RATIO, 4, beats per output word; any integer ≥ 2.
- clk  input  1  clock.
- rstn  input  1  reset; synchronous, active-low.
- i_data  input  DWIDTH  beat data.
- i_valid  input  1  beat valid.
- i_last  input  1  beat closes the current word; qualified by i_valid.
- o_ready  output  1  beat accepted when i_valid && o_ready.
- o_data  output  DWIDTH*RATIO  packed word.
- o_keep  output  RATIO  lane k holds a valid beat.
- o_last  output  1  word was closed by i_last.
- o_valid  output  1  word valid.
- i_ready  input  1  downstream ready; word handed off when o_valid && i_ready.

## Operation
- **State:**
  - enable register en_rg.
  - lane counter cnt_rg, width $clog2(RATIO), range 0..RATIO-1.
  - accumulator acc_rg, DWIDTH*RATIO bits.
  - keep accumulator kacc_rg, RATIO bits.
  - output registers: o_data, o_keep, o_last, o_valid.
- **o_ready** = en_rg && (!o_valid || i_ready).
  - This is a combinational path from i_ready to o_ready, and is intentional.
  - The upstream skid_buffer registers its own ready, so the path stops there.
- **Beat accept:** when i_valid && o_ready:
  - acc lane cnt_rg (bits cnt_rg*DWIDTH +: DWIDTH) ← i_data.
  - kacc bit cnt_rg ← 1.
- **Word close:** an accepted beat is final if cnt_rg == RATIO-1 or i_last == 1. On a final beat, in the same clock:
  - o_data ← acc with the current beat merged in.
  - o_keep ← kacc with bit cnt_rg set.
  - o_last ← i_last.
  - o_valid ← 1.
  - acc ← 0, kacc ← 0, cnt_rg ← 0.
- **Non-final beat:** cnt_rg increments by 1.
- **Lane order:** beat 0 goes to lane 0 (LSBs). Lanes not written in a partial word read 0 in o_data and 0 in o_keep.
- **Handoff:** when o_valid && i_ready and no final beat is accepted in the same cycle, o_valid ← 0. o_data, o_keep and o_last hold their values; only o_valid drops.
- **Simultaneous handoff and final beat:** the new word loads and o_valid stays 1. There is no bubble.
- **Stall:** while o_valid && !i_ready, o_ready = 0. The accumulator holds, and upstream must hold its beat.
- **Output stability:** o_data, o_keep and o_last change only when a new word loads, never while o_valid && !i_ready.
- **i_last:** ignored when i_valid is 0 or o_ready is 0.

## Timing
- **Reset (rstn == 0 at posedge):**
  - en_rg=0, cnt_rg=0, acc=0, kacc=0.
  - o_valid=0, o_data=0, o_keep=0, o_last=0.
  - Hence o_ready=0.
- **After reset release:** first posedge with rstn=1 sets en_rg=1. o_ready rises in the following cycle and is never 0 because of reset afterwards.
- **Reset mid-word:** any partial accumulation and any pending output word are discarded. Counter returns to 0, and no word is emitted.
- **Latency:** word valid on o_valid one cycle after the posedge that accepts its final beat.
- **Throughput:** with i_ready held 1 and i_valid held 1, one beat is accepted every cycle. One word is produced every RATIO cycles, with no idle cycles between words.
- **Back-pressure release:** o_ready rises combinationally in the same cycle that i_ready rises.

## Test plan
- **Reset and startup:** assert rstn=0 for 3 cycles, then release; i_valid=1 throughout. Required:
  - o_valid=0, o_data=0, o_keep=0, o_last=0 during reset.
  - o_ready=0 in the first cycle after release and 1 from the second.
  - No beat accepted before o_ready=1.
- **Full words, streaming:** DWIDTH=8, RATIO=4, i_ready=1, beats 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 back-to-back, i_last=0. Required:
  - o_data=0x44332211, o_keep=0xF, o_last=0, valid one cycle after beat 0x44.
  - Then o_data=0x88776655 on the very next word slot.
  - o_ready never drops.
- **Early close:** beats 0xAA, then 0xBB with i_last=1. Required: o_data=0x0000BBAA, o_keep=0x3, o_last=1. The next beat 0xCC lands in lane 0.
- **Single-beat word:** beat 0x5A with i_last=1 at cnt_rg=0. Required: o_data=0x0000005A, o_keep=0x1, o_last=1.
- **Back-pressure:** hold i_ready=0 after word 0x44332211 is presented, with upstream offering 0x55 for 5 cycles. Required:
  - o_ready=0 and o_valid=1 for those 5 cycles, with o_data stable.
  - On i_ready=1, 0x55 is accepted that cycle and the word hands off.
  - No beat is lost or duplicated.
- **Reset mid-word:** accept 0x01 and 0x02, pulse rstn=0 for 1 cycle, then send 0x10,0x20,0x30,0x40. Required: output is o_data=0x40302010, o_keep=0xF. Neither 0x01 nor 0x02 ever appears on o_data.
